// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb
//  Purpose  : Round-robin arbiter that feeds 32-bit words from four
//             requesters into a single UART transmitter. It tracks the
//             transmitter busy flag and reports per-requester grant and
//             completion pulses.
//  Options  : UART_TX_ARB_TIMEOUT_EN adds a per-wait-state timeout that
//             produces to_err / to_id.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
  parameter logic [31:0] TO_CYC = 32'd1000000
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] req_data,
  output logic [3:0]   gnt,
  output logic [3:0]   done,
  output logic         tx_en,
  output logic [31:0]  tx_data,
  input  logic         tx_busy,
`ifdef UART_TX_ARB_TIMEOUT_EN
  output logic         to_err,
  output logic [1:0]   to_id,
`endif
  output logic         arb_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  done_q, done_d;
  logic        tx_en_q, tx_en_d;
  logic [31:0] tx_data_q, tx_data_d;

  // Requests rotated so that bit 0 is the requester rr_ptr points at.
  logic [7:0]  req_dbl;
  logic [3:0]  req_rot;
  logic [1:0]  pick_off;
  logic [1:0]  pick;
  logic        pick_vld;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        to_err_q, to_err_d;
  logic [1:0]  to_id_q, to_id_d;
  logic        to_hit;
`endif

  assign req_dbl = {req, req};
  assign req_rot = req_dbl[rr_ptr_q +: 4];

  // Pick the first asserted requester at or above rr_ptr, wrapping mod 4.
  always_comb begin
    pick_off = 2'd0;
    pick_vld = 1'b1;
    casez (req_rot)
      4'b???1: pick_off = 2'd0;
      4'b??10: pick_off = 2'd1;
      4'b?100: pick_off = 2'd2;
      4'b1000: pick_off = 2'd3;
      default: pick_vld = 1'b0;
    endcase
    pick = rr_ptr_q + pick_off;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // The counter value seen here is cycles already spent in this state, so
  // the limit is hit on the cycle that would make it TO_CYC.
  assign to_hit = (state_q != IDLE) && ((cnt_q + 32'd1) >= TO_CYC);
`endif

  // Next-state and output decode for the arbitration FSM.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    gnt_d     = 4'b0000;
    done_d    = 4'b0000;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_err_d  = 1'b0;
    to_id_d   = to_id_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel_d     = pick;
          rr_ptr_d  = pick + 2'd1;
          tx_data_d = req_data[{pick, 5'd0} +: 32];
          gnt_d     = 4'b0001 << pick;
          tx_en_d   = 1'b1;
          state_d   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_d  = 4'b0001 << sel_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
    // A timeout overrides any normal progress in the same cycle.
    if (to_hit) begin
      state_d  = IDLE;
      done_d   = 4'b0000;
      to_err_d = 1'b1;
      to_id_d  = sel_q;
    end
    if (state_d != state_q) begin
      cnt_d = 32'd0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = 32'd0;
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 2'd0;
      sel_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      done_q    <= 4'b0000;
      tx_en_q   <= 1'b0;
      tx_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Timeout counter and sticky timeout identifier.
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q    <= 32'd0;
      to_err_q <= 1'b0;
      to_id_q  <= 2'd0;
    end else begin
      cnt_q    <= cnt_d;
      to_err_q <= to_err_d;
      to_id_q  <= to_id_d;
    end
  end

  assign to_err = to_err_q;
  assign to_id  = to_id_q;
`else
  // TO_CYC only matters with the timeout feature; a zero limit is
  // accepted here so the parameter stays referenced in every build.
  if (TO_CYC == 32'd0) begin : g_to_cyc_unused
  end
`endif

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign arb_busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arb
//  Purpose  : Scoreboard bench for uart_tx_arb. Directed stimulus pushes
//             expected grants/completions; a negedge monitor pops them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

  logic         clock = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [127:0] req_data = 128'd0;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic         tx_en;
  logic [31:0]  tx_data;
  logic         tx_busy = 1'b0;
  logic         arb_busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic         to_err;
  logic [1:0]   to_id;
`endif

  uart_tx_arb #(.TO_CYC(32'd16)) dut (
    .clock    (clock),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
`ifdef UART_TX_ARB_TIMEOUT_EN
    .to_err   (to_err),
    .to_id    (to_id),
`endif
    .arb_busy (arb_busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [31:0] data;
  } grant_t;

  grant_t      exp_gnt_q[$];
  logic [3:0]  exp_done_q[$];
  logic [1:0]  exp_toid_q[$];

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          fall_cyc = 0;
  int          tx_en_cyc = 0;
  logic        in_xfer = 1'b0;
  logic [31:0] last_data = 32'd0;
  grant_t      mon_g;
  logic [3:0]  mon_d;
  logic [1:0]  mon_id;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every DUT output event against the scoreboard.
  always @(negedge clock) begin
    if (rst) begin
      in_xfer = 1'b0;
    end else begin
      if (done != 4'b0000) begin
        if (exp_done_q.size() == 0) begin
          check("done_unexpected", {28'd0, done}, 32'd0);
        end else begin
          mon_d = exp_done_q.pop_front();
          check("done", {28'd0, done}, {28'd0, mon_d});
          check("done_latency", cyc - fall_cyc, 32'd1);
          check("tx_data_hold", tx_data, last_data);
        end
        in_xfer = 1'b0;
      end
`ifdef UART_TX_ARB_TIMEOUT_EN
      if (to_err) begin
        if (exp_toid_q.size() == 0) begin
          check("to_err_unexpected", {31'd0, to_err}, 32'd0);
        end else begin
          mon_id = exp_toid_q.pop_front();
          check("to_id", {30'd0, to_id}, {30'd0, mon_id});
          check("to_err_latency", cyc - tx_en_cyc, 32'd16);
        end
        in_xfer = 1'b0;
      end
`endif
      if (tx_en) begin
        if (exp_gnt_q.size() == 0) begin
          check("tx_en_unexpected", {31'd0, tx_en}, 32'd0);
        end else begin
          mon_g = exp_gnt_q.pop_front();
          check("gnt", {28'd0, gnt}, {28'd0, mon_g.gnt});
          check("tx_data", tx_data, mon_g.data);
          last_data = mon_g.data;
        end
        in_xfer   = 1'b1;
        tx_en_cyc = cyc;
      end else if (gnt != 4'b0000) begin
        check("gnt_without_tx_en", {28'd0, gnt}, 32'd0);
      end
      if (in_xfer) begin
        check("arb_busy_xfer", {31'd0, arb_busy}, 32'd1);
      end
    end
  end

  task automatic reset_dut();
    @(negedge clock);
    rst     = 1'b1;
    req     = 4'b0000;
    tx_busy = 1'b0;
    repeat (2) @(negedge clock);
    rst = 1'b0;
  endtask

  // Wait (bounded) for the start pulse; returns on the negedge it is seen.
  task automatic wait_en();
    int n;
    n = 0;
    @(negedge clock);
    while (!tx_en && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!tx_en) begin
      n_cmp++;
      n_err++;
      $display("FAIL tx_en_wait: got timeout expected tx_en within 100 cycles (cycle %0d)", cyc);
    end
  endtask

  // Transmitter model: busy for len cycles starting at the tx_en negedge.
  task automatic busy(input int len);
    tx_busy = 1'b1;
    repeat (len) @(negedge clock);
    tx_busy  = 1'b0;
    fall_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    reset_dut();
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_done", {28'd0, done}, 32'd0);
    check("rst_tx_en", {31'd0, tx_en}, 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_arb_busy", {31'd0, arb_busy}, 32'd0);
`ifdef UART_TX_ARB_TIMEOUT_EN
    check("rst_to_err", {31'd0, to_err}, 32'd0);
    check("rst_to_id", {30'd0, to_id}, 32'd0);
`endif

    // Single request from requester 2; data changes right after selection
    req_data = {32'h0, 32'hA5A5_1234, 32'h0, 32'h0};
    req      = 4'b0100;
    exp_gnt_q.push_back({4'b0100, 32'hA5A5_1234});
    exp_done_q.push_back(4'b0100);
    wait_en();
    req      = 4'b0000;
    req_data = {32'hFFFF_FFFF, 32'h5A5A_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    busy(44);
    repeat (3) @(negedge clock);

    // rr_ptr is 3 now: req 1001 -> requester 3 then requester 0
    req_data = {32'h3333_0003, 32'h0, 32'h0, 32'h0000_AAA0};
    req      = 4'b1001;
    exp_gnt_q.push_back({4'b1000, 32'h3333_0003});
    exp_gnt_q.push_back({4'b0001, 32'h0000_AAA0});
    exp_done_q.push_back(4'b1000);
    exp_done_q.push_back(4'b0001);
    wait_en();
    busy(6);
    wait_en();
    req = 4'b0000;
    busy(6);
    repeat (3) @(negedge clock);

    // Four held requests from rr_ptr 0: five transfers
    reset_dut();
    req_data = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    exp_gnt_q.push_back({4'b0001, 32'h1111_0001});
    exp_gnt_q.push_back({4'b0010, 32'h2222_0002});
    exp_gnt_q.push_back({4'b0100, 32'h3333_0003});
    exp_gnt_q.push_back({4'b1000, 32'h4444_0004});
    exp_gnt_q.push_back({4'b0001, 32'h1111_0001});
    exp_done_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0010);
    exp_done_q.push_back(4'b0100);
    exp_done_q.push_back(4'b1000);
    exp_done_q.push_back(4'b0001);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_en();
      if (i == 4) req = 4'b0000;
      busy(3);
    end
    repeat (3) @(negedge clock);

    // Reset during WAIT_DONE abandons the word; pending req re-arbitrated
    req_data = {32'hDEAD_0008, 32'h0, 32'h0, 32'h0};
    req      = 4'b1000;
    exp_gnt_q.push_back({4'b1000, 32'hDEAD_0008});
    wait_en();
    req      = 4'b0010;
    req_data = {32'h0, 32'h0, 32'hBEEF_0002, 32'h0};
    tx_busy  = 1'b1;
    repeat (5) @(negedge clock);
    rst     = 1'b1;
    tx_busy = 1'b0;
    @(negedge clock);
    check("midrst_gnt", {28'd0, gnt}, 32'd0);
    check("midrst_done", {28'd0, done}, 32'd0);
    check("midrst_tx_en", {31'd0, tx_en}, 32'd0);
    check("midrst_tx_data", tx_data, 32'd0);
    check("midrst_arb_busy", {31'd0, arb_busy}, 32'd0);
    exp_gnt_q.push_back({4'b0010, 32'hBEEF_0002});
    exp_done_q.push_back(4'b0010);
    rst = 1'b0;
    wait_en();
    req = 4'b0000;
    busy(4);
    repeat (3) @(negedge clock);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Timeout with the transmitter never going busy
    reset_dut();
    req_data = {32'h0, 32'h7777_0002, 32'h0, 32'h0};
    req      = 4'b0100;
    exp_gnt_q.push_back({4'b0100, 32'h7777_0002});
    exp_toid_q.push_back(2'd2);
    wait_en();
    req = 4'b0000;
    repeat (24) @(negedge clock);
    check("to_arb_busy_idle", {31'd0, arb_busy}, 32'd0);
    check("to_id_hold", {30'd0, to_id}, 32'd2);
    check("to_err_low", {31'd0, to_err}, 32'd0);
`endif

    repeat (2) @(negedge clock);
    check("gnt_queue_empty", exp_gnt_q.size(), 32'd0);
    check("done_queue_empty", exp_done_q.size(), 32'd0);
    check("toid_queue_empty", exp_toid_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter TO_CYC, default 32'd1000000, giving the timeout limit in clock cycles per wait state.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: requester i asks to send one 32-bit word.
REQ-005 The block SHALL have port req_data, input, 128 bits: word of requester i on bits [32i+31:32i].
REQ-006 The block SHALL have port gnt, output, 4 bits: one-cycle one-hot pulse when requester i's word is accepted.
REQ-007 The block SHALL have port done, output, 4 bits: one-cycle one-hot pulse when requester i's word has finished on the line.
REQ-008 The block SHALL have port tx_en, output, 1 bit: one-cycle start pulse to the UART transmitter.
REQ-009 The block SHALL have port tx_data, output, 32 bits: word to the UART transmitter, sent as 4 bytes.
REQ-010 The block SHALL have port tx_busy, input, 1 bit: UART transmitter busy flag.
REQ-011 The block SHALL have port arb_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-012 The block SHALL use states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-013 In IDLE with req nonzero, the block SHALL select the first asserted requester searching upward from rr_ptr with mod-4 wrap.
REQ-014 On selection it SHALL register tx_data from the selected slice, pulse tx_en and gnt[sel] in the following cycle, and go to WAIT_BUSY; latency from req to tx_en is 1 cycle.
REQ-015 On selection it SHALL set rr_ptr to (sel+1) mod 4.
REQ-016 req_data SHALL be sampled only in the selection cycle; tx_data SHALL hold that value until the next selection.
REQ-017 A requester that keeps req high after its gnt SHALL be treated as a new request; it is served again only after the other pending requesters.
REQ-018 In WAIT_BUSY, tx_busy=1 SHALL move the block to WAIT_DONE.
REQ-019 In WAIT_DONE, tx_busy=0 SHALL pulse done[sel] in the next cycle and return the block to IDLE.
REQ-020 A new selection SHALL be possible in the same cycle that done is pulsed.
REQ-021 tx_en SHALL never be asserted outside the cycle that follows a selection.
REQ-022 A req change during WAIT_BUSY or WAIT_DONE SHALL have no effect until IDLE.
REQ-023 Four simultaneous requests SHALL be served in the order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3.

Reset
REQ-024 On rst, the block SHALL set state=IDLE, rr_ptr=0, gnt=0, done=0, tx_en=0, tx_data=0 and arb_busy=0, with timeout outputs 0 when present.
REQ-025 rst mid-transfer SHALL abandon the word with no done pulse; requests are re-arbitrated from requester 0.

Configuration
REQ-026 With macro UART_TX_ARB_TIMEOUT_EN defined, the block SHALL add outputs to_err (1 bit) and to_id (2 bits).
REQ-027 With the macro defined, a 32-bit counter SHALL clear on each state entry and count every cycle spent in WAIT_BUSY or WAIT_DONE.
REQ-028 With the macro defined and the counter reaching TO_CYC, the block SHALL pulse to_err for one cycle, set to_id=sel, return to IDLE and give no done pulse.
REQ-029 With the macro defined, to_id SHALL hold its value until the next timeout or reset.
REQ-030 Without the macro, the counter and the to_err/to_id ports SHALL be absent and the wait states SHALL never time out.

Verification
REQ-031 The bench SHALL check: after reset, req=4'b0100 for 1 cycle with word 32'hA5A5_1234 -> next cycle tx_en=1, gnt=4'b0100, tx_data=32'hA5A5_1234.
REQ-032 The bench SHALL check: a transmitter model holding tx_busy high for 44 bit-times -> done=4'b0100 exactly one cycle after tx_busy falls, with arb_busy high for the whole transfer.
REQ-033 The bench SHALL check: req=4'b1111 held, rr_ptr=0 -> gnt order 0001, 0010, 0100, 1000, 0001 across five transfers.
REQ-034 The bench SHALL check: rr_ptr=3 with req=4'b1001 -> requester 3 granted first, then requester 0.
REQ-035 The bench SHALL check: rst asserted during WAIT_DONE -> all outputs 0 next cycle, no done pulse, and a pending req=4'b0010 granted after rst is released.
REQ-036 The bench SHALL check, with UART_TX_ARB_TIMEOUT_EN defined and TO_CYC=16: tx_busy held at 0 after tx_en -> to_err pulses 16 cycles after WAIT_BUSY entry, to_id=sel, state returns to IDLE, and done stays 0.
